// File: rtl/lift_pkg.sv
// Constants and encodings shared between the call panel and the lift controller.
package lift_pkg;

   localparam int N_FLOORS = 8;
   localparam int FLOOR_W  = 3;

   localparam logic UP   = 1'b0;
   localparam logic DOWN = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      OFFER,
      BUSY
   } state_t;

endpackage

// File: rtl/call_debounce.sv
// One call button: 2-flop synchronizer, 3-sample debounce on the shared tick,
// and a one-cycle pulse when the debounced level rises.
module call_debounce (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   input  logic i_tick,
   output logic o_press
);

   logic [1:0] r_sync;
   logic       r_level;
   logic       r_levelD;
   logic [1:0] r_run;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync   <= '0;
         r_level  <= 1'b0;
         r_levelD <= 1'b0;
         r_run    <= '0;
      end else begin
         r_sync   <= {r_sync[0], i_btn};
         r_levelD <= r_level;
         // The third consecutive opposite sample flips the level.
         if (i_tick) begin
            if (r_sync[1] != r_level) begin
               if (r_run == 2'd2) begin
                  r_level <= r_sync[1];
                  r_run   <= '0;
               end else begin
                  r_run <= r_run + 2'd1;
               end
            end else begin
               r_run <= '0;
            end
         end
      end
   end

   assign o_press = r_level & ~r_levelD;

endmodule

// File: rtl/call_panel.sv
// Floor-call front end: debounced buttons, pending-call latch, SCAN target
// selection and a valid/ack offer to the lift controller.
module call_panel
   import lift_pkg::*;
#(
   parameter int TICK_DIV = 100000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_FLOORS-1:0] btn,
   input  logic [FLOOR_W-1:0]  cur_floor,
   output logic                req_valid,
   output logic [FLOOR_W-1:0]  req_floor,
   input  logic                req_ack,
   input  logic                served_valid,
   input  logic [FLOOR_W-1:0]  served_floor,
   output logic [N_FLOORS-1:0] pending,
   output logic                dir
);

   localparam int CNT_W = $clog2(TICK_DIV);

   logic [CNT_W-1:0]    r_tickCnt;
   logic                w_tick;
   logic [N_FLOORS-1:0] w_press;
   logic [N_FLOORS-1:0] w_servedMask;
   logic [N_FLOORS-1:0] r_pending;
   logic                w_servedReq;
   state_t              r_state;
   state_t              w_stateNext;
   logic [FLOOR_W-1:0]  r_reqFloor;
   logic                r_dir;
   logic [FLOOR_W-1:0]  w_target;
   logic                w_dirNext;
   logic                w_foundLoGe;
   logic                w_foundHiLe;
   logic [FLOOR_W-1:0]  w_loGe;
   logic [FLOOR_W-1:0]  w_loGt;
   logic [FLOOR_W-1:0]  w_hiLe;
   logic [FLOOR_W-1:0]  w_hiLt;

   assign w_tick = (r_tickCnt == CNT_W'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tickCnt <= '0;
      end else if (w_tick) begin
         r_tickCnt <= '0;
      end else begin
         r_tickCnt <= r_tickCnt + CNT_W'(1);
      end
   end

   for (genvar g = 0; g < N_FLOORS; g++) begin : g_btn
      call_debounce u_debounce (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_btn   (btn[g]),
         .i_tick  (w_tick),
         .o_press (w_press[g])
      );
   end

   assign w_servedMask = served_valid ? (N_FLOORS'(1) << served_floor) : '0;
   assign w_servedReq  = served_valid && (served_floor == r_reqFloor);

   // Serve clears after press sets, so a same-cycle press at the cabin's floor is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
      end else begin
         r_pending <= (r_pending | w_press) & ~w_servedMask;
      end
   end

   always_comb begin
      w_foundLoGe = 1'b0;
      w_foundHiLe = 1'b0;
      w_loGe      = '0;
      w_loGt      = '0;
      w_hiLe      = '0;
      w_hiLt      = '0;
      for (int i = N_FLOORS - 1; i >= 0; i--) begin
         if (r_pending[i] && (i >= int'(cur_floor))) begin
            w_loGe      = FLOOR_W'(i);
            w_foundLoGe = 1'b1;
         end
         if (r_pending[i] && (i > int'(cur_floor))) begin
            w_loGt = FLOOR_W'(i);
         end
      end
      for (int i = 0; i < N_FLOORS; i++) begin
         if (r_pending[i] && (i <= int'(cur_floor))) begin
            w_hiLe      = FLOOR_W'(i);
            w_foundHiLe = 1'b1;
         end
         if (r_pending[i] && (i < int'(cur_floor))) begin
            w_hiLt = FLOOR_W'(i);
         end
      end
   end

   // Keep scanning in the current direction; reverse only when nothing lies ahead.
   always_comb begin
      w_target  = '0;
      w_dirNext = r_dir;
      if (r_dir == UP) begin
         if (w_foundLoGe) begin
            w_target = w_loGe;
         end else begin
            w_target  = w_hiLt;
            w_dirNext = DOWN;
         end
      end else begin
         if (w_foundHiLe) begin
            w_target = w_hiLe;
         end else begin
            w_target  = w_loGt;
            w_dirNext = UP;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE: begin
            if (r_pending != '0) begin
               w_stateNext = OFFER;
            end
         end
         OFFER: begin
            if (w_servedReq) begin
               w_stateNext = IDLE;
            end else if (req_ack) begin
               w_stateNext = BUSY;
            end
         end
         BUSY: begin
            if (w_servedReq) begin
               w_stateNext = IDLE;
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_reqFloor <= '0;
         r_dir      <= UP;
      end else if ((r_state == IDLE) && (r_pending != '0)) begin
         r_reqFloor <= w_target;
         r_dir      <= w_dirNext;
      end
   end

   assign req_valid = (r_state == OFFER);
   assign req_floor = r_reqFloor;
   assign pending   = r_pending;
   assign dir       = r_dir;

endmodule
